// File: rtl/ram_read_scheduler.sv
// Streams one layer's weight block from the shared RAM and steers each returned
// word into its destination unit/slot, then pulses sum_trigger to start accumulation.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// ISSUE | one RAM read per non-hold cycle, unit 0 slot 0 .. unit N-1 slot W-1
// DRAIN | no more reads; waiting for the delay pipe to empty
// SUM   | one-cycle sum_trigger pulse, then back to IDLE
module ram_read_scheduler #(
  parameter int NUM_UNITS      = 4,
  parameter int WORDS_PER_UNIT = 4,
  parameter int ADDR_W         = 32,
  parameter int LAYER_W        = 2,
  parameter int LAYER_STRIDE   = 16,
  parameter int RAM_LATENCY    = 1,
  parameter int SEL_W          = 3,
  parameter int UADDR_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer,
  input  logic               hold,
  output logic               RAM_en,
  output logic [ADDR_W-1:0]  RAM_address,
  output logic [SEL_W-1:0]   unit_sel,
  output logic [UADDR_W-1:0] unit_address,
  output logic               write,
  output logic               sum_trigger,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_SUM   = 2'd3;

  localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(NUM_UNITS - 1);
  localparam logic [UADDR_W-1:0] LAST_UADDR = UADDR_W'(WORDS_PER_UNIT - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;

  logic [ADDR_W-1:0]  cnt_addr;
  logic [SEL_W-1:0]   cnt_sel;
  logic [UADDR_W-1:0] cnt_uaddr;

  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  cur_addr;
  logic [SEL_W-1:0]   cur_sel;
  logic [UADDR_W-1:0] cur_uaddr;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [SEL_W-1:0]   nxt_sel;
  logic [UADDR_W-1:0] nxt_uaddr;
  logic               issue;
  logic               last_elem;

  // Delay pipe matching the RAM read latency; stage 0 takes the element just issued.
  logic [RAM_LATENCY-1:0] pipe_valid;
  logic [SEL_W-1:0]       pipe_sel   [RAM_LATENCY];
  logic [UADDR_W-1:0]     pipe_uaddr [RAM_LATENCY];

  // The start edge itself issues element 0, so in IDLE the "current" element is the block base.
  always_comb begin
    base = ADDR_W'(layer) * ADDR_W'(LAYER_STRIDE);
    if (state == S_IDLE) begin
      cur_addr  = base;
      cur_sel   = '0;
      cur_uaddr = '0;
    end else begin
      cur_addr  = cnt_addr;
      cur_sel   = cnt_sel;
      cur_uaddr = cnt_uaddr;
    end

    issue     = !hold && ((state == S_IDLE && start) || state == S_ISSUE);
    last_elem = (cur_sel == LAST_SEL) && (cur_uaddr == LAST_UADDR);

    nxt_addr  = cur_addr + ADDR_W'(1);
    nxt_sel   = cur_sel;
    nxt_uaddr = cur_uaddr + UADDR_W'(1);
    if (cur_uaddr == LAST_UADDR) begin
      nxt_uaddr = '0;
      nxt_sel   = cur_sel + SEL_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (issue && last_elem) ? S_DRAIN : S_ISSUE;
      end
      S_ISSUE: begin
        if (issue && last_elem) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (pipe_valid == '0) state_nxt = S_SUM;
      end
      S_SUM: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt_addr     <= '0;
      cnt_sel      <= '0;
      cnt_uaddr    <= '0;
      pipe_valid   <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_sel[i]   <= '0;
        pipe_uaddr[i] <= '0;
      end
      RAM_en       <= 1'b0;
      RAM_address  <= '0;
      unit_sel     <= '0;
      unit_address <= '0;
      write        <= 1'b0;
      sum_trigger  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != S_IDLE);
      sum_trigger <= (state_nxt == S_SUM);

      RAM_en <= issue;
      if (issue) RAM_address <= cur_addr;

      if (issue) begin
        cnt_addr  <= nxt_addr;
        cnt_sel   <= nxt_sel;
        cnt_uaddr <= nxt_uaddr;
      end else begin
        cnt_addr  <= cur_addr;
        cnt_sel   <= cur_sel;
        cnt_uaddr <= cur_uaddr;
      end

      // Pipe always shifts; a hold or drain cycle pushes a bubble.
      pipe_valid[0] <= issue;
      pipe_sel[0]   <= cur_sel;
      pipe_uaddr[0] <= cur_uaddr;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_sel[i]   <= pipe_sel[i-1];
        pipe_uaddr[i] <= pipe_uaddr[i-1];
      end

      write <= pipe_valid[RAM_LATENCY-1];
      if (pipe_valid[RAM_LATENCY-1]) begin
        unit_sel     <= pipe_sel[RAM_LATENCY-1];
        unit_address <= pipe_uaddr[RAM_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_ram_read_scheduler.sv
// Directed bench for ram_read_scheduler: three parameterisations share one set of inputs,
// each load is checked cycle by cycle against hand-derived issue/write timing.
module tb_ram_read_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] layer;
  logic       hold;

  logic        a_en, a_write, a_sum, a_busy;
  logic [31:0] a_addr;
  logic [2:0]  a_sel, a_uaddr;
  logic        b_en, b_write, b_sum, b_busy;
  logic [31:0] b_addr;
  logic [2:0]  b_sel, b_uaddr;
  logic        c_en, c_write, c_sum, c_busy;
  logic [3:0]  c_addr;
  logic [2:0]  c_sel, c_uaddr;

  ram_read_scheduler dut_a (
    .clk(clk), .reset(reset), .start(start), .layer(layer), .hold(hold),
    .RAM_en(a_en), .RAM_address(a_addr), .unit_sel(a_sel), .unit_address(a_uaddr),
    .write(a_write), .sum_trigger(a_sum), .busy(a_busy)
  );

  ram_read_scheduler #(.NUM_UNITS(2), .WORDS_PER_UNIT(3), .RAM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .layer(layer), .hold(hold),
    .RAM_en(b_en), .RAM_address(b_addr), .unit_sel(b_sel), .unit_address(b_uaddr),
    .write(b_write), .sum_trigger(b_sum), .busy(b_busy)
  );

  ram_read_scheduler #(.ADDR_W(4), .LAYER_STRIDE(6)) dut_c (
    .clk(clk), .reset(reset), .start(start), .layer(layer), .hold(hold),
    .RAM_en(c_en), .RAM_address(c_addr), .unit_sel(c_sel), .unit_address(c_uaddr),
    .write(c_write), .sum_trigger(c_sum), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cur_id = 0;

  logic        s_en, s_write, s_sum, s_busy;
  logic [63:0] s_addr, s_sel, s_uaddr;

  always_comb begin
    s_en = 1'b0; s_write = 1'b0; s_sum = 1'b0; s_busy = 1'b0;
    s_addr = '0; s_sel = '0; s_uaddr = '0;
    case (cur_id)
      0: begin
        s_en = a_en; s_write = a_write; s_sum = a_sum; s_busy = a_busy;
        s_addr = 64'(a_addr); s_sel = 64'(a_sel); s_uaddr = 64'(a_uaddr);
      end
      1: begin
        s_en = b_en; s_write = b_write; s_sum = b_sum; s_busy = b_busy;
        s_addr = 64'(b_addr); s_sel = 64'(b_sel); s_uaddr = 64'(b_uaddr);
      end
      default: begin
        s_en = c_en; s_write = c_write; s_sum = c_sum; s_busy = c_busy;
        s_addr = 64'(c_addr); s_sel = 64'(c_sel); s_uaddr = 64'(c_uaddr);
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index of the element issued at edge E0+c, or -1 when no issue happens at that edge.
  // Hold, when used, covers the two edges right after the 5th issue (edges 5..5+hl-1).
  function automatic int issue_at(input int c, input int nt, input int hl);
    int k;
    if (c < 0) return -1;
    if (hl > 0 && c >= 5 && c < 5 + hl) return -1;
    k = (hl > 0 && c >= 5 + hl) ? c - hl : c;
    if (k >= nt) return -1;
    return k;
  endfunction

  // One full load on instance id; s1/s2 are cycles after which start is re-raised (must be ignored).
  task automatic run_load(input int id, input int lay, input logic [63:0] base, input int nt,
                          input int w, input int lat, input logic [63:0] amask, input int hl,
                          input int s1, input int s2);
    int writes = 0;
    int sums   = 0;
    int cend;
    int ki, kw;
    cur_id = id;
    cend   = nt + lat + hl + 1;
    layer  = 2'(lay);
    start  = 1'b1;
    for (int c = 0; c <= cend; c++) begin
      tick();
      if (c == 0) layer = 2'(lay ^ 1);
      ki = issue_at(c, nt, hl);
      kw = issue_at(c - lat, nt, hl);
      chk("ram_en", 64'(s_en), 64'(ki >= 0));
      if (ki >= 0) chk("ram_addr", s_addr, (base + 64'(ki)) & amask);
      chk("write", 64'(s_write), 64'(kw >= 0));
      if (kw >= 0) begin
        chk("unit_sel", s_sel, 64'(kw / w));
        chk("unit_addr", s_uaddr, 64'(kw % w));
      end
      chk("sum_trigger", 64'(s_sum), 64'(c == nt + lat + hl));
      chk("busy", 64'(s_busy), 64'(c <= nt + lat + hl));
      if (s_write) writes++;
      if (s_sum) sums++;
      start = (c == s1 || c == s2);
      hold  = (hl > 0 && c + 1 >= 5 && c + 1 < 5 + hl);
    end
    start = 1'b0;
    hold  = 1'b0;
    chk("write_total", 64'(writes), 64'(nt));
    chk("sum_total", 64'(sums), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  int writes_seen;
  int late_events;

  initial begin
    reset = 1'b0; start = 1'b0; layer = 2'd0; hold = 1'b0;
    repeat (3) tick();
    cur_id = 0;
    chk("rst_ram_en", 64'(s_en), 64'd0);
    chk("rst_ram_addr", s_addr, 64'd0);
    chk("rst_write", 64'(s_write), 64'd0);
    chk("rst_unit_sel", s_sel, 64'd0);
    chk("rst_unit_addr", s_uaddr, 64'd0);
    chk("rst_sum", 64'(s_sum), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_busy_b", 64'(b_busy), 64'd0);
    reset = 1'b1;
    tick();

    // Defaults, layer 1; start re-raised in ISSUE and in SUM, then a new load at E0+19 on layer 2.
    run_load(0, 1, 64'd16, 16, 4, 1, 64'hFFFF_FFFF, 0, 2, 17);
    run_load(0, 2, 64'd32, 16, 4, 1, 64'hFFFF_FFFF, 0, -1, -1);
    repeat (2) tick();

    // Two hold cycles after the 5th issue.
    run_load(0, 1, 64'd16, 16, 4, 1, 64'hFFFF_FFFF, 2, -1, -1);
    repeat (2) tick();

    // Latency 3, 2 units x 3 words.
    do_reset();
    tick();
    run_load(1, 1, 64'd16, 6, 3, 3, 64'hFFFF_FFFF, 0, -1, -1);
    repeat (2) tick();

    // 4-bit address, stride 6, layer 3: base 18 wraps to 2, addresses 2..15,0,1.
    do_reset();
    tick();
    run_load(2, 3, 64'd2, 16, 4, 1, 64'hF, 0, -1, -1);
    repeat (2) tick();

    // Reset mid-ISSUE after 7 writes.
    do_reset();
    tick();
    cur_id = 0;
    writes_seen = 0;
    layer = 2'd1;
    start = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      tick();
      start = 1'b0;
      if (s_write) writes_seen++;
    end
    chk("pre_reset_writes", 64'(writes_seen), 64'd7);
    reset = 1'b0;
    tick();
    chk("mid_rst_ram_en", 64'(s_en), 64'd0);
    chk("mid_rst_ram_addr", s_addr, 64'd0);
    chk("mid_rst_write", 64'(s_write), 64'd0);
    chk("mid_rst_unit_sel", s_sel, 64'd0);
    chk("mid_rst_unit_addr", s_uaddr, 64'd0);
    chk("mid_rst_sum", 64'(s_sum), 64'd0);
    chk("mid_rst_busy", 64'(s_busy), 64'd0);
    reset = 1'b1;
    late_events = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (s_write || s_sum || s_en || s_busy) late_events++;
    end
    chk("post_rst_quiet", 64'(late_events), 64'd0);
    run_load(0, 1, 64'd16, 16, 4, 1, 64'hFFFF_FFFF, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
